// File: rtl/cache_ctrl_pkg.sv
// Shared encodings for the N-way cache controller: FSM state codes, data-load
// select codes and the way-index width helper.
package cache_ctrl_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE      = 2'd0;
    localparam state_t ST_WRITEBACK = 2'd1;
    localparam state_t ST_FILL      = 2'd2;
    localparam state_t ST_WT_WRITE  = 2'd3;

    localparam logic [1:0] LDS_NONE = 2'b00;
    localparam logic [1:0] LDS_PEND = 2'b01;
    localparam logic [1:0] LDS_CPU  = 2'b10;
    localparam logic [1:0] LDS_PMEM = 2'b11;

    function automatic int way_width(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/cache_control_nway_plru_tree.sv
// Tree pseudo-LRU: heap-ordered node bits (children 2i+1 / 2i+2, bit 0 = left).
// Produces the victim way and the tree after an access to access_way.
module plru_tree
    import cache_ctrl_pkg::*;
#(
    parameter int NUM_WAYS = 4,
    localparam int WAY_W   = way_width(NUM_WAYS)
) (
    input  logic [NUM_WAYS-2:0] plru_bits,
    input  logic [WAY_W-1:0]    access_way,
    output logic [WAY_W-1:0]    victim,
    output logic [NUM_WAYS-2:0] plru_next
);

    logic [WAY_W-1:0] vnode;
    logic             vbit;
    logic [WAY_W-1:0] unode;
    logic             ubit;

    always_comb begin
        victim = '0;
        vnode  = '0;
        vbit   = 1'b0;
        for (int l = 0; l < WAY_W; l++) begin
            vbit                 = plru_bits[vnode];
            victim[WAY_W-1-l]    = vbit;
            vnode                = (vnode << 1) + WAY_W'(1) + WAY_W'(vbit);
        end
    end

    // Each node on the accessed way's path is turned to point at the other subtree.
    always_comb begin
        plru_next = plru_bits;
        unode     = '0;
        ubit      = 1'b0;
        for (int l = 0; l < WAY_W; l++) begin
            ubit             = access_way[WAY_W-1-l];
            plru_next[unode] = ~ubit;
            unode            = (unode << 1) + WAY_W'(1) + WAY_W'(ubit);
        end
    end

endmodule

// File: rtl/cache_control_nway.sv
// N-way set-associative cache controller: hit/miss sequencing, victim choice,
// write-back or write-through policy and saturating hit/miss counters.
//
// state        | meaning
// ST_IDLE      | serve hits, detect misses, choose victim
// ST_WRITEBACK | write dirty victim line to pmem
// ST_FILL      | read missing line from pmem into victim way
// ST_WT_WRITE  | write-through of a CPU write hit to pmem
module cache_control_nway
    import cache_ctrl_pkg::*;
#(
    parameter int NUM_WAYS   = 4,
    parameter bit WRITE_BACK = 1'b1,
    parameter int CNT_W      = 32,
    localparam int WAY_W     = way_width(NUM_WAYS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mem_read,
    input  logic                mem_write,
    output logic                mem_resp,
    input  logic [NUM_WAYS-1:0] hit_way,
    input  logic [NUM_WAYS-1:0] valid_way,
    input  logic [NUM_WAYS-1:0] dirty_way,
    input  logic [NUM_WAYS-2:0] plru_bits,
    output logic [NUM_WAYS-2:0] plru_next,
    output logic                plru_we,
    output logic [WAY_W-1:0]    way_sel,
    output logic                load_tag,
    output logic                set_valid,
    output logic                set_dirty,
    output logic                clr_dirty,
    output logic [1:0]          load_data_select,
    output logic                data_write_select,
    output logic                pmem_addr_select,
    output logic                pmem_read,
    output logic                pmem_write,
    input  logic                pmem_resp,
    output logic                if_miss,
    output logic [CNT_W-1:0]    hit_count,
    output logic [CNT_W-1:0]    miss_count
);

    state_t           state, state_nxt;
    logic [WAY_W-1:0] victim_q, latch_val;
    logic             latch_way, miss_start;
    logic             req, hit_any, has_free, victim_dirty;
    logic [WAY_W-1:0] hit_idx, free_idx, plru_victim, victim;

    assign req     = mem_read | mem_write;
    assign hit_any = |hit_way;

    always_comb begin
        hit_idx = '0;
        for (int i = 0; i < NUM_WAYS; i++)
            if (hit_way[i]) hit_idx = WAY_W'(i);
    end

    always_comb begin
        free_idx = '0;
        has_free = 1'b0;
        for (int i = NUM_WAYS - 1; i >= 0; i--)
            if (!valid_way[i]) begin
                free_idx = WAY_W'(i);
                has_free = 1'b1;
            end
    end

    assign victim       = has_free ? free_idx : plru_victim;
    assign victim_dirty = valid_way[victim] & dirty_way[victim];
    assign way_sel      = (state == ST_IDLE) ? hit_idx : victim_q;
    assign if_miss      = (state == ST_WRITEBACK) || (state == ST_FILL);

    plru_tree #(.NUM_WAYS(NUM_WAYS)) u_plru (
        .plru_bits  (plru_bits),
        .access_way (way_sel),
        .victim     (plru_victim),
        .plru_next  (plru_next)
    );

    always_comb begin
        state_nxt         = state;
        mem_resp          = 1'b0;
        plru_we           = 1'b0;
        load_tag          = 1'b0;
        set_valid         = 1'b0;
        set_dirty         = 1'b0;
        clr_dirty         = 1'b0;
        load_data_select  = LDS_NONE;
        data_write_select = 1'b0;
        pmem_addr_select  = 1'b0;
        pmem_read         = 1'b0;
        pmem_write        = 1'b0;
        miss_start        = 1'b0;
        latch_way         = 1'b0;
        latch_val         = victim;
        case (state)
            ST_IDLE: begin
                // rst_n gate keeps every strobe quiet while reset is asserted
                if (req && rst_n) begin
                    if (hit_any) begin
                        if (!mem_write) begin
                            mem_resp = 1'b1;
                            plru_we  = 1'b1;
                        end else if (WRITE_BACK) begin
                            mem_resp         = 1'b1;
                            plru_we          = 1'b1;
                            load_data_select = LDS_CPU;
                            set_dirty        = 1'b1;
                        end else begin
                            // hit way is held so the WT data write targets it
                            state_nxt = ST_WT_WRITE;
                            latch_way = 1'b1;
                            latch_val = hit_idx;
                        end
                    end else begin
                        miss_start = 1'b1;
                        latch_way  = 1'b1;
                        state_nxt  = (WRITE_BACK && victim_dirty) ? ST_WRITEBACK : ST_FILL;
                    end
                end
            end
            ST_WRITEBACK: begin
                pmem_write       = 1'b1;
                pmem_addr_select = 1'b1;
                clr_dirty        = 1'b1;
                if (pmem_resp) state_nxt = ST_FILL;
            end
            ST_FILL: begin
                pmem_read         = 1'b1;
                data_write_select = 1'b1;
                set_valid         = 1'b1;
                load_data_select  = LDS_PEND;
                if (pmem_resp) begin
                    load_data_select = LDS_PMEM;
                    load_tag         = 1'b1;
                    plru_we          = 1'b1;
                    state_nxt        = ST_IDLE;
                end
            end
            ST_WT_WRITE: begin
                pmem_write = 1'b1;
                if (pmem_resp) begin
                    load_data_select = LDS_CPU;
                    mem_resp         = 1'b1;
                    plru_we          = 1'b1;
                    state_nxt        = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            victim_q   <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            state <= state_nxt;
            if (latch_way) victim_q <= latch_val;
            if (mem_resp && (hit_count != '1)) hit_count <= hit_count + CNT_W'(1);
            if (miss_start && (miss_count != '1)) miss_count <= miss_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_cache_control_nway.sv
// Bench for cache_control_nway: a write-back instance (2-bit counters) and a
// write-through instance, checked against a heap-walk PLRU model and counters.
module tb_cache_control_nway;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] hit_way, valid_way, dirty_way;
    logic [2:0] plru_bits;

    logic       a_mem_read, a_mem_write, a_pmem_resp;
    logic       a_mem_resp, a_plru_we, a_load_tag, a_set_valid, a_set_dirty, a_clr_dirty;
    logic       a_dws, a_pas, a_pmem_read, a_pmem_write, a_if_miss;
    logic [2:0] a_plru_next;
    logic [1:0] a_way_sel, a_lds, a_hit_count, a_miss_count;

    logic       b_mem_read, b_mem_write, b_pmem_resp;
    logic       b_mem_resp, b_plru_we, b_load_tag, b_set_valid, b_set_dirty, b_clr_dirty;
    logic       b_dws, b_pas, b_pmem_read, b_pmem_write, b_if_miss;
    logic [2:0] b_plru_next;
    logic [1:0] b_way_sel, b_lds;
    logic [7:0] b_hit_count, b_miss_count;

    int checks = 0;
    int errors = 0;
    int a_hits = 0, a_misses = 0, b_hits = 0, b_misses = 0;

    int         r_kind, r_hway, r_wait;
    bit         r_hit;
    logic [3:0] r_valid, r_dirty;
    logic [2:0] r_plru;

    always #5 clk = ~clk;

    cache_control_nway #(.NUM_WAYS(4), .WRITE_BACK(1'b1), .CNT_W(2)) u_wb (
        .clk(clk), .rst_n(rst_n), .mem_read(a_mem_read), .mem_write(a_mem_write),
        .mem_resp(a_mem_resp), .hit_way(hit_way), .valid_way(valid_way), .dirty_way(dirty_way),
        .plru_bits(plru_bits), .plru_next(a_plru_next), .plru_we(a_plru_we), .way_sel(a_way_sel),
        .load_tag(a_load_tag), .set_valid(a_set_valid), .set_dirty(a_set_dirty),
        .clr_dirty(a_clr_dirty), .load_data_select(a_lds), .data_write_select(a_dws),
        .pmem_addr_select(a_pas), .pmem_read(a_pmem_read), .pmem_write(a_pmem_write),
        .pmem_resp(a_pmem_resp), .if_miss(a_if_miss), .hit_count(a_hit_count),
        .miss_count(a_miss_count)
    );

    cache_control_nway #(.NUM_WAYS(4), .WRITE_BACK(1'b0), .CNT_W(8)) u_wt (
        .clk(clk), .rst_n(rst_n), .mem_read(b_mem_read), .mem_write(b_mem_write),
        .mem_resp(b_mem_resp), .hit_way(hit_way), .valid_way(valid_way), .dirty_way(dirty_way),
        .plru_bits(plru_bits), .plru_next(b_plru_next), .plru_we(b_plru_we), .way_sel(b_way_sel),
        .load_tag(b_load_tag), .set_valid(b_set_valid), .set_dirty(b_set_dirty),
        .clr_dirty(b_clr_dirty), .load_data_select(b_lds), .data_write_select(b_dws),
        .pmem_addr_select(b_pas), .pmem_read(b_pmem_read), .pmem_write(b_pmem_write),
        .pmem_resp(b_pmem_resp), .if_miss(b_if_miss), .hit_count(b_hit_count),
        .miss_count(b_miss_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat_inc(input int v, input int maxv);
        return (v < maxv) ? v + 1 : v;
    endfunction

    // Lowest invalid way, else walk the heap from the root.
    function automatic int ref_victim(input logic [3:0] valid, input logic [2:0] plru);
        int node;
        for (int i = 0; i < 4; i++)
            if (!valid[i]) return i;
        node = 0;
        while (node < 3) node = plru[node] ? 2 * node + 2 : 2 * node +1;
        return node - 3;
    endfunction

    // Climb from the leaf, pointing every parent at the sibling subtree.
    function automatic logic [2:0] ref_touch(input logic [2:0] plru, input int way);
        int child, parent;
        logic [2:0] r;
        r = plru;
        child = way + 3;
        while (child > 0) begin
            parent    = (child - 1) / 2;
            r[parent] = (child == 2 * parent + 1);
            child     = parent;
        end
        return r;
    endfunction

    task automatic wb_txn(input bit rd, input bit wr, input bit hit, input int hway,
                          input logic [3:0] valid, input logic [3:0] dirty,
                          input logic [2:0] plru, input int wait_cyc);
        int v;
        logic [2:0] p2;
        valid_way  = hit ? (valid | (4'b0001 << hway)) : valid;
        dirty_way  = dirty;
        plru_bits  = plru;
        hit_way    = hit ? (4'b0001 << hway) : 4'b0000;
        a_mem_read = rd;
        a_mem_write = wr;
        #1;
        if (hit) begin
            check("hit_resp", a_mem_resp, 1);
            check("hit_way_sel", a_way_sel, hway);
            check("hit_plru_we", a_plru_we, 1);
            check("hit_plru_next", a_plru_next, ref_touch(plru, hway));
            check("hit_set_dirty", a_set_dirty, 32'(wr));
            check("hit_lds", a_lds, wr ? 2'b10 : 2'b00);
            tick();
            a_hits = sat_inc(a_hits, 3);
        end else begin
            v = ref_victim(valid_way, plru);
            check("miss_no_resp", a_mem_resp, 0);
            check("miss_no_we", a_plru_we, 0);
            tick();
            a_misses = sat_inc(a_misses, 3);
            #1;
            check("miss_count", a_miss_count, a_misses);
            check("miss_if", a_if_miss, 1);
            check("miss_way_sel", a_way_sel, v);
            if (valid_way[v] && dirty[v]) begin
                check("wb_pmem_write", a_pmem_write, 1);
                check("wb_addr_sel", a_pas, 1);
                check("wb_clr_dirty", a_clr_dirty, 1);
                check("wb_no_read", a_pmem_read, 0);
                repeat (wait_cyc) begin
                    tick(); #1;
                    check("wb_hold", a_pmem_write, 1);
                end
                a_pmem_resp = 1'b1;
                tick();
                a_pmem_resp = 1'b0;
                #1;
            end else begin
                check("clean_no_wb", a_pmem_write, 0);
            end
            check("fill_pmem_read", a_pmem_read, 1);
            check("fill_no_write", a_pmem_write, 0);
            check("fill_set_valid", a_set_valid, 1);
            check("fill_lds_pend", a_lds, 2'b01);
            check("fill_dws", a_dws, 1);
            check("fill_way_sel", a_way_sel, v);
            repeat (wait_cyc) begin
                tick(); #1;
                check("fill_hold", a_pmem_read, 1);
            end
            a_pmem_resp = 1'b1;
            #1;
            check("fill_done_lds", a_lds, 2'b11);
            check("fill_done_tag", a_load_tag, 1);
            check("fill_done_we", a_plru_we, 1);
            check("fill_done_plru", a_plru_next, ref_touch(plru, v));
            check("fill_done_no_resp", a_mem_resp, 0);
            tick();
            a_pmem_resp = 1'b0;
            p2 = ref_touch(plru, v);
            plru_bits = p2;
            hit_way   = 4'b0001 << v;
            valid_way = valid_way | (4'b0001 << v);
            #1;
            check("post_fill_resp", a_mem_resp, 1);
            check("post_fill_if", a_if_miss, 0);
            check("post_fill_plru", a_plru_next, ref_touch(p2, v));
            check("post_fill_dirty", a_set_dirty, 32'(wr));
            tick();
            a_hits = sat_inc(a_hits, 3);
        end
        a_mem_read  = 1'b0;
        a_mem_write = 1'b0;
        hit_way     = 4'b0000;
        #1;
        check("hit_count", a_hit_count, a_hits);
        check("miss_count_end", a_miss_count, a_misses);
    endtask

    task automatic random_txns(input int n);
        for (int k = 0; k < n; k++) begin
            r_kind  = $urandom_range(0, 2);
            r_hit   = ($urandom_range(0, 1) == 1);
            r_hway  = $urandom_range(0, 3);
            r_valid = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
            r_dirty = 4'($urandom);
            r_plru  = 3'($urandom);
            r_wait  = $urandom_range(0, 3);
            wb_txn(r_kind != 1, r_kind != 0, r_hit, r_hway, r_valid, r_dirty, r_plru, r_wait);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        hit_way = '0; valid_way = '0; dirty_way = '0; plru_bits = '0;
        a_mem_read = 0; a_mem_write = 0; a_pmem_resp = 0;
        b_mem_read = 0; b_mem_write = 0; b_pmem_resp = 0;
        #1;
        check("rst_resp", a_mem_resp, 0);
        check("rst_pmem_read", a_pmem_read, 0);
        check("rst_pmem_write", a_pmem_write, 0);
        check("rst_if_miss", a_if_miss, 0);
        check("rst_hit_count", a_hit_count, 0);
        check("rst_miss_count", a_miss_count, 0);
        check("rst_way_sel", a_way_sel, 0);
        check("rst_b_hit_count", b_hit_count, 0);
        tick(); tick();
        rst_n = 1'b1;

        // clean miss, all valid, PLRU 000 -> way 0, tree 011 after fill
        wb_txn(1, 0, 0, 0, 4'hF, 4'h0, 3'b000, 2);
        // invalid way 2 wins over PLRU
        wb_txn(1, 0, 0, 0, 4'b1011, 4'h0, 3'b111, 0);
        // dirty victim way 1 goes through write-back first
        wb_txn(0, 1, 0, 0, 4'hF, 4'b0010, 3'b010, 1);
        // counters now at 3 and must hold
        wb_txn(1, 0, 1, 2, 4'hF, 4'h0, 3'b101, 0);
        wb_txn(1, 1, 1, 3, 4'hF, 4'h0, 3'b000, 0);
        check("sat_hit_hold", a_hit_count, 2'd3);
        random_txns(20);

        // write-through write hit on way 2, pmem_resp arrives in the sixth cycle
        valid_way = 4'hF; dirty_way = 4'h0; plru_bits = 3'b000; hit_way = 4'b0100;
        b_mem_write = 1'b1;
        #1;
        check("wt_no_resp", b_mem_resp, 0);
        check("wt_no_dirty", b_set_dirty, 0);
        for (int c = 2; c <= 5; c++) begin
            tick(); #1;
            check("wt_pmem_write", b_pmem_write, 1);
            check("wt_addr_sel", b_pas, 0);
            check("wt_wait_no_resp", b_mem_resp, 0);
            check("wt_way_sel", b_way_sel, 2);
        end
        tick();
        b_pmem_resp = 1'b1;
        #1;
        check("wt_resp", b_mem_resp, 1);
        check("wt_lds", b_lds, 2'b10);
        check("wt_plru_we", b_plru_we, 1);
        check("wt_plru_next", b_plru_next, ref_touch(3'b000, 2));
        check("wt_resp_no_dirty", b_set_dirty, 0);
        tick();
        b_pmem_resp = 1'b0; b_mem_write = 1'b0; hit_way = 4'b0000;
        b_hits = sat_inc(b_hits, 255);
        #1;
        check("wt_idle_write_drop", b_pmem_write, 0);
        check("wt_hit_count", b_hit_count, b_hits);

        // write-through write miss: dirty victim skips write-back
        valid_way = 4'hF; dirty_way = 4'hF; plru_bits = 3'b110;
        b_mem_write = 1'b1;
        #1;
        check("wtm_no_resp", b_mem_resp, 0);
        tick();
        b_misses = sat_inc(b_misses, 255);
        #1;
        check("wtm_fill", b_pmem_read, 1);
        check("wtm_no_wb", b_pmem_write, 0);
        check("wtm_no_clr", b_clr_dirty, 0);
        check("wtm_way_sel", b_way_sel, ref_victim(4'hF, 3'b110));
        check("wtm_miss_count", b_miss_count, b_misses);
        b_pmem_resp = 1'b1;
        #1;
        check("wtm_load_tag", b_load_tag, 1);
        tick();
        b_pmem_resp = 1'b0;
        hit_way   = 4'b0001 << ref_victim(4'hF, 3'b110);
        plru_bits = ref_touch(3'b110, ref_victim(4'hF, 3'b110));
        #1;
        check("wtm_hit_no_resp", b_mem_resp, 0);
        check("wtm_hit_no_dirty", b_set_dirty, 0);
        tick(); #1;
        check("wtm_wt_write", b_pmem_write, 1);
        b_pmem_resp = 1'b1;
        #1;
        check("wtm_resp", b_mem_resp, 1);
        check("wtm_lds", b_lds, 2'b10);
        tick();
        b_pmem_resp = 1'b0; b_mem_write = 1'b0; hit_way = 4'b0000;
        b_hits = sat_inc(b_hits, 255);
        #1;
        check("wtm_hit_count", b_hit_count, b_hits);

        // stray pmem_resp while idle
        b_pmem_resp = 1'b1;
        tick();
        b_pmem_resp = 1'b0;
        #1;
        check("stray_no_read", b_pmem_read, 0);
        check("stray_no_write", b_pmem_write, 0);
        check("stray_if_miss", b_if_miss, 0);
        check("stray_miss_count", b_miss_count, b_misses);

        // reset while filling
        valid_way = 4'hF; dirty_way = 4'h0; plru_bits = 3'b000; hit_way = 4'b0000;
        a_mem_read = 1'b1;
        #1;
        tick(); #1;
        check("rstf_in_fill", a_pmem_read, 1);
        rst_n = 1'b0;
        #1;
        a_hits = 0; a_misses = 0; b_hits = 0; b_misses = 0;
        check("rstf_read_drop", a_pmem_read, 0);
        check("rstf_if_miss", a_if_miss, 0);
        check("rstf_hit_count", a_hit_count, a_hits);
        check("rstf_miss_count", a_miss_count, a_misses);
        check("rstf_b_hit_count", b_hit_count, b_hits);
        a_mem_read = 1'b0;
        tick();
        rst_n = 1'b1;
        tick(); #1;
        check("rstf_idle_read", a_pmem_read, 0);
        check("rstf_idle_if", a_if_miss, 0);
        check("rstf_idle_resp", a_mem_resp, 0);
        random_txns(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
